// File: rtl/return_guard_stack.sv
// return_guard_stack: shadow call stack checking resolved returns against decoded call links.
// Optional RGS_STRICT_UNDERFLOW_EN: a return on an empty stack counts as a violation.
module return_guard_stack #(
    parameter int VLEN = 32,
    parameter int DEPTH = 16,
    parameter logic [VLEN-2:0] KEY = 31'h73fa06c2
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       call_valid_i,
    input  logic [VLEN-1:0]            call_link_i,
    input  logic                       ret_valid_i,
    input  logic [VLEN-1:0]            ret_target_i,
    input  logic                       flush_i,
    output logic                       crash_o,
    output logic [VLEN-1:0]            crash_addr_o,
    output logic [$clog2(DEPTH):0]     depth_o,
    output logic                       overflow_o
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

    logic [VLEN-2:0] mem [DEPTH];
    logic [AW-1:0]   tp, tp_top;
    logic [AW:0]     cnt;
    logic [VLEN-2:0] push_val;
    logic            empty, do_ret, do_push, bad, viol;

    always_comb begin
        tp_top   = tp - AW'(1);
        empty    = cnt == '0;
        push_val = call_link_i[VLEN-2:0] ^ KEY;
        do_ret   = ret_valid_i && !flush_i && !empty;
        do_push  = call_valid_i && !flush_i;
        bad      = !ret_target_i[VLEN-1] || ret_target_i[VLEN-2:0] != mem[tp_top];
`ifdef RGS_STRICT_UNDERFLOW_EN
        viol     = ret_valid_i && !flush_i && (empty || bad);
`else
        viol     = do_ret && bad;
`endif
    end

    // A call paired with a checked return overwrites the slot just popped.
    always_ff @(posedge clk_i)
        if (do_push)
            mem[do_ret ? tp_top : tp] <= push_val;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            tp           <= '0;
            cnt          <= '0;
            crash_o      <= 1'b0;
            crash_addr_o <= '0;
            overflow_o   <= 1'b0;
        end else begin
            crash_o <= viol;
            if (viol)
                crash_addr_o <= ret_target_i;
            if (flush_i) begin
                tp  <= '0;
                cnt <= '0;
            end else if (do_push && !do_ret) begin
                tp <= tp + AW'(1);
                if (cnt == FULL)
                    overflow_o <= 1'b1;
                else
                    cnt <= cnt + (AW+1)'(1);
            end else if (do_ret && !do_push) begin
                tp  <= tp_top;
                cnt <= cnt - (AW+1)'(1);
            end
        end
    end

    assign depth_o = cnt;
endmodule

// File: tb/tb_return_guard_stack.sv
// tb_return_guard_stack: queue-based reference model with a scoreboard monitor.
module tb_return_guard_stack;
    localparam int DEPTH = 16;
    localparam logic [30:0] KEY = 31'h73fa06c2;

    typedef struct {
        logic        crash;
        logic [31:0] addr;
        logic [4:0]  depth;
        logic        ovf;
    } exp_t;

    logic        clk = 0, rst = 0;
    logic        call_valid = 0, ret_valid = 0, flush = 0;
    logic [31:0] call_link = 0, ret_target = 0;
    logic        crash;
    logic [31:0] crash_addr;
    logic [4:0]  depth;
    logic        overflow;

    int vectors = 0, miscompares = 0;
    exp_t exp_q[$];
    logic [30:0] stk[$];
    logic        m_ovf = 0;
    logic [31:0] m_addr = 0;

    return_guard_stack dut (
        .clk_i(clk), .rst_i(rst),
        .call_valid_i(call_valid), .call_link_i(call_link),
        .ret_valid_i(ret_valid), .ret_target_i(ret_target),
        .flush_i(flush),
        .crash_o(crash), .crash_addr_o(crash_addr),
        .depth_o(depth), .overflow_o(overflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] enc(input logic [30:0] d);
        return {1'b0, d ^ KEY};
    endfunction

    always @(posedge clk) begin
        #1;
        if (!rst && exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            chk("crash", 32'(crash), 32'(e.crash));
            chk("crash_addr", crash_addr, e.addr);
            chk("depth", 32'(depth), 32'(e.depth));
            chk("overflow", 32'(overflow), 32'(e.ovf));
        end
    end

    task automatic step(input logic cv, input logic [31:0] link, input logic rv,
                        input logic [31:0] tgt, input logic fl);
        exp_t e;
        @(negedge clk);
        call_valid = cv; call_link = link; ret_valid = rv; ret_target = tgt; flush = fl;
        e.crash = 0;
        if (fl) stk.delete();
        else begin
            if (rv) begin
                if (stk.size() > 0) begin
                    if (!tgt[31] || tgt[30:0] != stk[$]) e.crash = 1;
                    void'(stk.pop_back());
                end else begin
`ifdef RGS_STRICT_UNDERFLOW_EN
                    e.crash = 1;
`endif
                end
            end
            if (cv) begin
                if (stk.size() == DEPTH) begin
                    void'(stk.pop_front());
                    m_ovf = 1;
                end
                stk.push_back(link[30:0] ^ KEY);
            end
        end
        if (e.crash) m_addr = tgt;
        e.addr = m_addr;
        e.depth = 5'(stk.size());
        e.ovf = m_ovf;
        exp_q.push_back(e);
    endtask

    task automatic idle();
        step(0, 0, 0, 0, 0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        call_valid = 0; ret_valid = 0; flush = 0;
        rst = 1;
        #1;
        chk("rst_crash", 32'(crash), 0);
        chk("rst_addr", crash_addr, 0);
        chk("rst_depth", 32'(depth), 0);
        chk("rst_ovf", 32'(overflow), 0);
        stk.delete(); m_ovf = 0; m_addr = 0;
        @(negedge clk);
        rst = 0;
    endtask

    initial begin
        logic [31:0] tgt;
        #1 rst = 1;
        #2;
        chk("init_crash", 32'(crash), 0);
        chk("init_depth", 32'(depth), 0);
        do_reset();
        // basic match
        step(1, 32'h73fa06c2 ^ 32'h00000104, 0, 0, 0);
        step(0, 0, 1, 32'h80000104, 0);
        idle();
        // mismatching target, then MSB-clear target
        step(1, enc(31'h104), 0, 0, 0);
        step(0, 0, 1, 32'h80000200, 0);
        idle(); idle();
        step(1, enc(31'h104), 0, 0, 0);
        step(0, 0, 1, 32'h00000104, 0);
        idle();
        // overflow: 17 pushes, 16 matching pops, one underflow return
        for (int i = 1; i <= 17; i++) step(1, enc(31'(i * 16)), 0, 0, 0);
        for (int i = 17; i >= 2; i--) step(0, 0, 1, {1'b1, 31'(i * 16)}, 0);
        step(0, 0, 1, 32'h80000010, 0);
        idle();
        // same-cycle call and return
        step(1, enc(31'h400), 0, 0, 0);
        step(1, enc(31'h500), 0, 0, 0);
        step(1, enc(31'h300), 1, 32'h80000500, 0);
        step(0, 0, 1, 32'h80000300, 0);
        step(0, 0, 1, 32'h80000400, 0);
        // flush beats a mismatching return
        step(1, enc(31'h600), 0, 0, 0);
        step(1, enc(31'h700), 1, 32'h80000999, 1);
        idle();
        // reset during a crash pulse
        step(1, enc(31'h104), 0, 0, 0);
        step(0, 0, 1, 32'h80000bad, 0);
        @(negedge clk);
        chk("crash_before_rst", 32'(crash), 1);
        call_valid = 0; ret_valid = 0;
        rst = 1;
        #1;
        chk("crash_rst_drop", 32'(crash), 0);
        chk("depth_rst_drop", 32'(depth), 0);
        stk.delete(); m_ovf = 0; m_addr = 0;
        @(negedge clk);
        rst = 0;
        // randomized traffic
        for (int n = 0; n < 1500; n++) begin
            if (stk.size() > 0 && $urandom_range(0, 3) != 0) tgt = {1'b1, stk[$]};
            else tgt = {$urandom_range(0, 7) != 0, 31'($urandom)};
            step($urandom_range(0, 99) < 40, {1'b0, 31'($urandom)},
                 $urandom_range(0, 99) < 45, tgt, $urandom_range(0, 99) < 3);
        end
        idle();
        for (int w = 0; w < 10 && exp_q.size() > 0; w++) @(negedge clk);
        if (exp_q.size() > 0) begin
            vectors++;
            miscompares++;
            $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/return_guard_stack.md
# return_guard_stack

Hardware shadow call stack that checks every resolved return in the execute stage against the link address recorded when the matching call resolved. The branch unit writes link values to rd in XOR-encoded form with MSB 0, and decodes return targets to MSB 1. This block takes that encoded link on each call, stores its decoded form in a circular LIFO, and compares it with each decoded return target. A mismatch raises a registered crash pulse that the controller uses to redirect or halt.

## Interface
Parameters:
- `VLEN`, 32: virtual address width; bit `VLEN-1` is the encoding marker.
- `DEPTH`, 16: number of stack entries; must be a power of two and at least 2.
- `KEY`, 31'h73fa06c2: XOR key, `VLEN-1` bits wide, identical to the branch unit's key.

Ports:
- `clk_i` in 1: clock.
- `rst_i` in 1: asynchronous, active-high reset.
- `call_valid_i` in 1: a call resolved this cycle (JAL or JALR with rd = x1).
- `call_link_i` in VLEN: encoded link value written to rd.
- `ret_valid_i` in 1: a return resolved this cycle (JALR, rd = x0, rs1 = x1).
- `ret_target_i` in VLEN: decoded return target address.
- `flush_i` in 1: empty the stack (context switch or exception entry).
- `crash_o` out 1: one-cycle pulse on a return violation.
- `crash_addr_o` out VLEN: `ret_target_i` of the most recent violation.
- `depth_o` out $clog2(DEPTH)+1: current number of valid entries.
- `overflow_o` out 1: sticky; set when an entry was dropped because the stack was full.

## Operation
- Storage: `DEPTH` × (`VLEN-1`) bits. Top pointer `tp` is $clog2(DEPTH) bits and wraps modulo `DEPTH`. Occupancy counter `cnt` runs from 0 to `DEPTH`.
- Push (call): store `call_link_i[VLEN-2:0] ^ KEY`, then increment `tp`.
  - If `cnt == DEPTH`, the oldest entry is overwritten, `cnt` stays at `DEPTH`, and `overflow_o` is set.
- Pop/check (return), when `cnt > 0`:
  - Violation if `ret_target_i[VLEN-1] != 1`.
  - Violation if `ret_target_i[VLEN-2:0]` differs from the entry at `tp-1`.
  - The entry is popped whether or not a violation occurred.
- Return when `cnt == 0` (underflow): see Configuration.
- Call and return in the same cycle:
  - The return is checked against the current top first.
  - The pushed value then replaces that top slot.
  - `tp` and `cnt` are unchanged.
  - The same-cycle call/return case applies only when `cnt > 0`. When empty, the return follows the underflow rule and the call pushes normally.
- `flush_i` has highest priority. It sets `tp = 0` and `cnt = 0`, suppresses the check and the push in that cycle, and does not clear `overflow_o`.
- `overflow_o` is cleared only by reset.

## Timing
- Reset values: `crash_o` = 0, `crash_addr_o` = 0, `depth_o` = 0, `overflow_o` = 0. Storage content is don't-care.
- Reset asserted mid-operation clears all state immediately, including any pending crash pulse.
- Stack, pointer, and `depth_o` update on the clock edge after the event. A push in cycle N can be checked by a return in cycle N+1.
- `crash_o` is registered: it is high in cycle N+1 for a violating return in cycle N, for exactly one cycle. Back-to-back violations give back-to-back pulses.
- `crash_addr_o` loads together with `crash_o` and holds until the next violation.
- There is no backpressure: every valid is consumed in its cycle.

## Configuration
- `RGS_STRICT_UNDERFLOW_EN`:
  - Defined: a return with `cnt == 0` is a violation, so `crash_o` pulses and `crash_addr_o` captures the target.
  - Undefined: a return on an empty stack is ignored (no crash, no state change). This supports code that returns past the monitored entry point.

## Test plan
- Reset, then call with `call_link_i` = 32'h73fa06c2 ^ 32'h00000104 (decodes to 0x104), then a return with `ret_target_i` = 32'h80000104 on the next cycle → no crash; `depth_o` goes 0 → 1 → 0.
- Same call, then a return with `ret_target_i` = 32'h80000200 → `crash_o` high for exactly one cycle, one cycle after the return; `crash_addr_o` = 32'h80000200; `depth_o` = 0.
- Return target 32'h00000104 (MSB clear) against a matching entry → crash.
- Push 17 calls with decoded links 0x10, 0x20, …, 0x110, then 16 matching returns in reverse order → no crash; `overflow_o` = 1; `depth_o` stays 16 until the returns, then reaches 0. A 17th return → crash only with `RGS_STRICT_UNDERFLOW_EN` defined, ignored otherwise.
- Two entries on the stack, call (decoded 0x300) and return matching the top, both in the same cycle → no crash; `depth_o` stays 2; the next return matches 0x300.
- `flush_i` in the same cycle as a mismatching return → no crash; `depth_o` = 0. Assert `rst_i` during a crash pulse → `crash_o` drops immediately.
